// File: rtl/vote_pkg.sv
// ---------------------------------------------------------------------------
// vote_pkg : shared types and defaults for the majority-vote round controller
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2
  } state_t;

  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF   = 8;
  localparam int N_VOTERS    = 3;
  localparam int TIMER_W     = 8;

endpackage

`default_nettype wire

// File: rtl/majority.sv
// ---------------------------------------------------------------------------
// majority : combinational 2-of-3 majority voter
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module majority (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic m
);

  assign m = (a & b) | (a & c) | (b & c);

endmodule

`default_nettype wire

// File: rtl/vote_controller.sv
// ---------------------------------------------------------------------------
// vote_controller : sequences one ballot-collection round among three voters
//                   and returns a registered majority decision
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vote_controller
  import vote_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_bit,
  output logic [N_VOTERS-1:0] vote_ack,
  output logic                busy,
  output logic                result,
  output logic                result_valid,
  output logic                timed_out,
  output logic [N_VOTERS-1:0] voted_mask,
  output logic [CNT_W-1:0]    round_cnt
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_t              state;
  state_t              state_nx;
  logic [N_VOTERS-1:0] got;
  logic [N_VOTERS-1:0] bits;
  logic [N_VOTERS-1:0] new_votes;
  logic [N_VOTERS-1:0] got_nx;
  logic [N_VOTERS-1:0] counted;
  logic [TIMER_W-1:0]  timer;
  logic                maj;

  // Only first-time ballots during COLLECT are latched and acknowledged.
  always_comb begin
    new_votes = '0;
    if (state == COLLECT) begin
      new_votes = vote_valid & ~got;
    end
    got_nx   = got | new_votes;
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = COLLECT;
      COLLECT: if ((&got_nx) || (timer == TIMER_LAST)) state_nx = DECIDE;
      DECIDE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Missing ballots are forced to 0 before voting.
  assign counted = bits & got;

  majority u_majority (
    .a (counted[0]),
    .b (counted[1]),
    .c (counted[2]),
    .m (maj)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      got          <= '0;
      bits         <= '0;
      timer        <= '0;
      vote_ack     <= '0;
      result       <= 1'b0;
      result_valid <= 1'b0;
      timed_out    <= 1'b0;
      voted_mask   <= '0;
      round_cnt    <= '0;
    end else begin
      vote_ack     <= new_votes;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            got   <= '0;
            bits  <= '0;
            timer <= '0;
          end
        end
        COLLECT: begin
          got   <= got_nx;
          bits  <= (bits & ~new_votes) | (vote_bit & new_votes);
          timer <= timer + TIMER_W'(1);
        end
        DECIDE: begin
          result       <= maj;
          voted_mask   <= got;
          timed_out    <= ~&got;
          result_valid <= 1'b1;
          round_cnt    <= round_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: doc/vote_controller.md
# vote_controller

Sequences one majority-vote round among three voter agents and drives the existing combinational `majority` voter. A round starts on a `start` pulse. The block collects one ballot bit from each voter over a valid/ack handshake, bounded by a timeout window. It then presents the latched ballots to `majority` and returns a registered result with a one-cycle valid pulse. It sits between the voter agents and any consumer of the decision.

## Interface
- `TIMEOUT`, 15: number of COLLECT cycles before the round closes with missing ballots; legal range 1..255.
- `CNT_W`, 8: width of the round counter.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request to open a round; sampled only in IDLE.
- `vote_valid`  in  3  per-voter ballot valid; bit i belongs to voter i.
- `vote_bit`  in  3  per-voter ballot value.
- `vote_ack`  out  3  registered one-cycle pulse per voter whose ballot was latched.
- `busy`  out  1  high whenever state is not IDLE.
- `result`  out  1  registered majority decision; held until the next decision.
- `result_valid`  out  1  one-cycle pulse marking a new `result`.
- `timed_out`  out  1  registered with `result`; 1 if any ballot was missing.
- `voted_mask`  out  3  registered with `result`; bit i = voter i's ballot was counted.
- `round_cnt`  out  CNT_W  number of completed rounds, wraps modulo 2^CNT_W.

## Operation
- States:
  - IDLE: waits for `start`; `start`=1 at an edge moves to COLLECT and clears `got`, `bits` and `timer`.
  - COLLECT: at each edge, for every i with `vote_valid[i]`=1 and `got[i]`=0, latches `bits[i]`<=`vote_bit[i]`, sets `got[i]`, and drives `vote_ack[i]`=1 for the next cycle. A voter holds valid until it sees ack. Valid from an already-counted voter is ignored with no second ack. `timer` increments each COLLECT edge.
  - Exit from COLLECT: goes to DECIDE at the edge where `got` becomes 3'b111 (including ballots latched at that same edge), or at the edge where `timer`==TIMEOUT-1, whichever comes first.
  - DECIDE: at the next edge, performs all of the following, then goes to IDLE:
    - `result` <= majority(`bits` & `got`); a missing ballot counts as 0.
    - `voted_mask` <= `got`.
    - `timed_out` <= ~&`got`.
    - `result_valid` <= 1 for that one cycle.
    - `round_cnt` <= `round_cnt`+1.
- `start` in COLLECT or DECIDE is ignored and not queued.
- `vote_valid` outside COLLECT is ignored and gets no ack.
- Simultaneous events:
  - A ballot arriving on the timeout edge is counted.
  - All three ballots on the same edge give three acks in the same cycle.

## Timing
- Reset values: state IDLE; `vote_ack`=0, `busy`=0, `result`=0, `result_valid`=0, `timed_out`=0, `voted_mask`=0, `round_cnt`=0; internal `got`, `bits`, `timer`=0.
- Reset mid-round aborts the round asynchronously: no `result_valid`, pending acks dropped, `round_cnt` cleared.
- Minimum latency: `start` sampled at edge T0, all ballots latched at T1, `result_valid` high in the cycle after T2.
- Timeout latency: `result_valid` high in the cycle after edge T0+TIMEOUT+1.
- Back-to-back rounds: `start` asserted during the `result_valid` cycle is accepted, because the state is already IDLE.

## Structure
- Shared package `vote_pkg` holds:
  - state enum {IDLE, COLLECT, DECIDE};
  - default constants for `TIMEOUT` and `CNT_W`;
  - voter count 3.
- Sub-module: one instance of the existing `majority` (a, b, c -> m), fed from `bits` & `got`.
- The FSM, timer and handshake logic stay inline.

## Test plan
- Reset, then `start`; all voters present valid=1 with bits 1,1,0 in the next cycle:
  - acks 3'b111 for one cycle;
  - `result_valid` pulse with `result`=1, `timed_out`=0, `voted_mask`=3'b111, `round_cnt`=1.
- Staggered ballots: voter 0 = 0 at cycle 1, voter 2 = 0 at cycle 4, voter 1 = 1 at cycle 6:
  - one ack each;
  - `result`=0; decision one cycle after the last latch.
- Timeout with TIMEOUT=15: only voter 1 votes 1:
  - `result_valid` 16 cycles after the start edge plus one;
  - `result`=0, `timed_out`=1, `voted_mask`=3'b010.
- Voter 0 holds valid for 5 cycles after its ack while others are late:
  - exactly one ack for voter 0;
  - its first latched bit is used.
- Ballot on the timeout edge: voter 2 goes valid exactly at `timer`=TIMEOUT-1 -> `voted_mask[2]`=1 and it is counted.
- Reset during COLLECT after two acks:
  - all outputs return to 0 immediately and no `result_valid` appears;
  - a subsequent full round gives `round_cnt`=1.
- Exhaustive sweep: all 8 ballot combinations, plus `round_cnt` wrap with CNT_W=2 after 4 rounds -> 0.
